// File: rtl/dpram_port_arbiter.sv
// Two-requester arbiter for one port of a latency-wrapped RAM, with RAW hazard stall and halt/drain.
// Define ARB_FIXED_PRIO_EN for fixed priority (req0 over req1); default build is round-robin.
module dpram_port_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int WR_LATENCY = 1,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_req0,
    input  logic                  i_req1,
    input  logic                  i_we0,
    input  logic                  i_we1,
    input  logic [ADDR_WIDTH-1:0] i_addr0,
    input  logic [ADDR_WIDTH-1:0] i_addr1,
    input  logic [DATA_WIDTH-1:0] i_wdata0,
    input  logic [DATA_WIDTH-1:0] i_wdata1,
    output logic                  o_gnt0,
    output logic                  o_gnt1,
    output logic                  o_rvalid0,
    output logic                  o_rvalid1,
    output logic [DATA_WIDTH-1:0] o_rdata,
    input  logic                  i_halt,
    output logic                  o_halted,
    output logic                  o_mem_en,
    output logic                  o_mem_we,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [DATA_WIDTH-1:0] o_mem_din,
    input  logic [DATA_WIDTH-1:0] i_mem_dout
);

    localparam int WSB_N = WR_LATENCY + 1;
    localparam int TAG_N = RD_LATENCY + 1;

    typedef enum logic [1:0] {
        ACTIVE = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t                state, state_next;
    logic [WSB_N-1:0]      wsb_vld;
    logic [ADDR_WIDTH-1:0] wsb_addr [WSB_N];
    logic [TAG_N-1:0]      tag_vld;
    logic [TAG_N-1:0]      tag_id;

    logic                  hit0, hit1;
    logic                  accept, elig0, elig1;
    logic                  grant, sel_we, win_write, win_read;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  empty;

    // A read may not pass a write to the same address that has not yet landed in the RAM.
    always_comb begin
        hit0 = 1'b0;
        hit1 = 1'b0;
        for (int i = 0; i < WSB_N; i++) begin
            if (wsb_vld[i] && (wsb_addr[i] == i_addr0)) hit0 = 1'b1;
            if (wsb_vld[i] && (wsb_addr[i] == i_addr1)) hit1 = 1'b1;
        end
    end

    assign accept = (state == ACTIVE) && !i_halt;
    assign elig0  = accept && i_req0 && !(!i_we0 && hit0);
    assign elig1  = accept && i_req1 && !(!i_we1 && hit1);

`ifdef ARB_FIXED_PRIO_EN
    assign o_gnt0 = elig0;
    assign o_gnt1 = elig1 && !elig0;
`else
    logic rr_ptr;

    assign o_gnt0 = elig0 && (!elig1 || !rr_ptr);
    assign o_gnt1 = elig1 && (!elig0 || rr_ptr);

    // Pointer always lands on the requester that did not win.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= 1'b0;
        end else if (o_gnt0 || o_gnt1) begin
            rr_ptr <= o_gnt0;
        end
    end
`endif

    assign grant     = o_gnt0 || o_gnt1;
    assign sel_we    = o_gnt1 ? i_we1    : i_we0;
    assign sel_addr  = o_gnt1 ? i_addr1  : i_addr0;
    assign sel_data  = o_gnt1 ? i_wdata1 : i_wdata0;
    assign win_write = grant && sel_we;
    assign win_read  = grant && !sel_we;
    assign empty     = !(|wsb_vld) && !(|tag_vld);

    // ---- issue stage: registered RAM command ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_mem_en   <= 1'b0;
            o_mem_we   <= 1'b0;
            o_mem_addr <= '0;
            o_mem_din  <= '0;
        end else begin
            o_mem_en <= grant;
            o_mem_we <= win_write;
            if (grant) begin
                o_mem_addr <= sel_addr;
                o_mem_din  <= sel_data;
            end
        end
    end

    // ---- write scoreboard and read tag pipelines ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wsb_vld <= '0;
            tag_vld <= '0;
            tag_id  <= '0;
            for (int i = 0; i < WSB_N; i++) wsb_addr[i] <= '0;
        end else begin
            wsb_vld     <= {wsb_vld[WSB_N-2:0], win_write};
            wsb_addr[0] <= sel_addr;
            for (int i = 1; i < WSB_N; i++) wsb_addr[i] <= wsb_addr[i-1];
            tag_vld     <= {tag_vld[TAG_N-2:0], win_read};
            tag_id      <= {tag_id[TAG_N-2:0], o_gnt1};
        end
    end

    // ---- return stage: data captured on the edge the tag reaches the last stage ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_rdata <= '0;
        end else if (tag_vld[RD_LATENCY-1]) begin
            o_rdata <= i_mem_dout;
        end
    end

    assign o_rvalid0 = tag_vld[RD_LATENCY] && !tag_id[RD_LATENCY];
    assign o_rvalid1 = tag_vld[RD_LATENCY] &&  tag_id[RD_LATENCY];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ACTIVE;
        else        state <= state_next;
    end

    // Drain always completes to HALTED, even if halt is withdrawn mid-drain.
    always_comb begin
        state_next = state;
        case (state)
            ACTIVE:  if (i_halt) state_next = DRAIN;
            DRAIN:   if (empty) state_next = HALTED;
            HALTED:  if (!i_halt) state_next = ACTIVE;
            default: state_next = ACTIVE;
        endcase
    end

    assign o_halted = (state == HALTED);

endmodule

// File: tb/tb_dpram_port_arbiter.sv
// Directed testbench for dpram_port_arbiter (WR_LATENCY=2, RD_LATENCY=1) with a small RAM model.
module tb_dpram_port_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0, req1, we0, we1;
    logic [3:0] addr0, addr1;
    logic [7:0] wdata0, wdata1;
    logic       gnt0, gnt1, rvalid0, rvalid1;
    logic [7:0] rdata;
    logic       halt, halted;
    logic       mem_en, mem_we;
    logic [3:0] mem_addr;
    logic [7:0] mem_din, mem_dout;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    dpram_port_arbiter #(
        .DATA_WIDTH(8), .ADDR_WIDTH(4), .WR_LATENCY(2), .RD_LATENCY(1)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req0(req0), .i_req1(req1), .i_we0(we0), .i_we1(we1),
        .i_addr0(addr0), .i_addr1(addr1), .i_wdata0(wdata0), .i_wdata1(wdata1),
        .o_gnt0(gnt0), .o_gnt1(gnt1), .o_rvalid0(rvalid0), .o_rvalid1(rvalid1),
        .o_rdata(rdata), .i_halt(halt), .o_halted(halted),
        .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
        .o_mem_din(mem_din), .i_mem_dout(mem_dout)
    );

    // RAM model: read data follows the command address in the command cycle;
    // a write lands two edges after its command is presented.
    logic [7:0] mem [16] = '{default: 8'h00};
    logic       wp0_v = 1'b0, wp1_v = 1'b0;
    logic [3:0] wp0_a = 4'h0, wp1_a = 4'h0;
    logic [7:0] wp0_d = 8'h00, wp1_d = 8'h00;

    assign mem_dout = mem[mem_addr];

    always @(posedge clk) begin
        if (wp1_v) mem[wp1_a] <= wp1_d;
        wp1_v <= wp0_v;
        wp1_a <= wp0_a;
        wp1_d <= wp0_d;
        wp0_v <= mem_en && mem_we;
        wp0_a <= mem_addr;
        wp0_d <= mem_din;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        #1;
        n_tests++; if (mem_en !== 1'b0) begin n_fail++; $display("FAIL reset_mem_en: got %b want 0", mem_en); end
        n_tests++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
        n_tests++; if (mem_addr !== 4'h0) begin n_fail++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
        n_tests++; if (mem_din !== 8'h00) begin n_fail++; $display("FAIL reset_mem_din: got %h want 00", mem_din); end
        n_tests++; if ({rvalid0, rvalid1} !== 2'b00) begin n_fail++; $display("FAIL reset_rvalid: got %b want 00", {rvalid0, rvalid1}); end
        n_tests++; if (rdata !== 8'h00) begin n_fail++; $display("FAIL reset_rdata: got %h want 00", rdata); end
        n_tests++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted: got %b want 0", halted); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_contention();
        req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0; addr0 = 4'd1; addr1 = 4'd2;
        for (int i = 0; i < 8; i++) begin
            if (i == 6) begin req0 = 1'b0; req1 = 1'b0; end
            #1;
            if (i < 6) begin
                n_tests++; if (gnt0 !== (i % 2 == 0)) begin n_fail++; $display("FAIL contention_gnt0[%0d]: got %b want %b", i, gnt0, (i % 2 == 0)); end
                n_tests++; if (gnt1 !== (i % 2 == 1)) begin n_fail++; $display("FAIL contention_gnt1[%0d]: got %b want %b", i, gnt1, (i % 2 == 1)); end
            end
            if (i >= 2) begin
                n_tests++; if (rvalid0 !== (i % 2 == 0)) begin n_fail++; $display("FAIL contention_rvalid0[%0d]: got %b want %b", i, rvalid0, (i % 2 == 0)); end
                n_tests++; if (rvalid1 !== (i % 2 == 1)) begin n_fail++; $display("FAIL contention_rvalid1[%0d]: got %b want %b", i, rvalid1, (i % 2 == 1)); end
            end
            tick();
        end
        tick();
    endtask

    task automatic test_write();
        req0 = 1'b1; we0 = 1'b1; addr0 = 4'd3; wdata0 = 8'h5A;
        #1;
        n_tests++; if ({gnt0, gnt1} !== 2'b10) begin n_fail++; $display("FAIL write_gnt: got %b want 10", {gnt0, gnt1}); end
        tick();
        req0 = 1'b0; we0 = 1'b0;
        #1;
        n_tests++; if ({mem_en, mem_we} !== 2'b11) begin n_fail++; $display("FAIL write_en_we: got %b want 11", {mem_en, mem_we}); end
        n_tests++; if (mem_addr !== 4'd3) begin n_fail++; $display("FAIL write_addr: got %h want 3", mem_addr); end
        n_tests++; if (mem_din !== 8'h5A) begin n_fail++; $display("FAIL write_din: got %h want 5a", mem_din); end
        for (int i = 0; i < 3; i++) begin
            tick();
            #1;
            n_tests++; if ({rvalid0, rvalid1, mem_en} !== 3'b000) begin n_fail++; $display("FAIL write_no_rvalid[%0d]: got %b want 000", i, {rvalid0, rvalid1, mem_en}); end
        end
        tick();
    endtask

    task automatic test_single_read();
        req0 = 1'b1; we0 = 1'b0; addr0 = 4'd3;
        #1;
        n_tests++; if (gnt0 !== 1'b1) begin n_fail++; $display("FAIL read_gnt0: got %b want 1", gnt0); end
        tick();
        req0 = 1'b0;
        #1;
        n_tests++; if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 4'd3}) begin n_fail++; $display("FAIL read_cmd: got %b%b%h want 103", mem_en, mem_we, mem_addr); end
        n_tests++; if (rvalid0 !== 1'b0) begin n_fail++; $display("FAIL read_rvalid_early: got %b want 0", rvalid0); end
        tick();
        #1;
        n_tests++; if ({rvalid0, rvalid1} !== 2'b10) begin n_fail++; $display("FAIL read_rvalid: got %b want 10", {rvalid0, rvalid1}); end
        n_tests++; if (rdata !== 8'h5A) begin n_fail++; $display("FAIL read_rdata: got %h want 5a", rdata); end
        tick();
        #1;
        n_tests++; if (rvalid0 !== 1'b0) begin n_fail++; $display("FAIL read_rvalid_pulse: got %b want 0", rvalid0); end
        tick();
    endtask

    task automatic test_raw_hazard();
        req0 = 1'b1; we0 = 1'b1; addr0 = 4'd7; wdata0 = 8'hC3;
        #1;
        n_tests++; if (gnt0 !== 1'b1) begin n_fail++; $display("FAIL raw_wr_gnt: got %b want 1", gnt0); end
        tick();
        req0 = 1'b0; we0 = 1'b0; req1 = 1'b1; we1 = 1'b0; addr1 = 4'd7;
        #1;
        n_tests++; if (gnt1 !== 1'b0) begin n_fail++; $display("FAIL raw_stall1: got %b want 0", gnt1); end
        tick();
        req0 = 1'b1; addr0 = 4'd1;
        #1;
        n_tests++; if ({gnt0, gnt1} !== 2'b10) begin n_fail++; $display("FAIL raw_stall2_other_gnt: got %b want 10", {gnt0, gnt1}); end
        tick();
        req0 = 1'b0;
        #1;
        n_tests++; if (gnt1 !== 1'b0) begin n_fail++; $display("FAIL raw_stall3: got %b want 0", gnt1); end
        n_tests++; if (mem_addr !== 4'd1) begin n_fail++; $display("FAIL raw_other_addr: got %h want 1", mem_addr); end
        tick();
        #1;
        n_tests++; if (gnt1 !== 1'b1) begin n_fail++; $display("FAIL raw_release: got %b want 1", gnt1); end
        n_tests++; if (rvalid0 !== 1'b1) begin n_fail++; $display("FAIL raw_other_rvalid: got %b want 1", rvalid0); end
        tick();
        req1 = 1'b0;
        #1;
        n_tests++; if ({mem_we, mem_addr} !== {1'b0, 4'd7}) begin n_fail++; $display("FAIL raw_read_cmd: got %b%h want 07", mem_we, mem_addr); end
        tick();
        #1;
        n_tests++; if ({rvalid0, rvalid1} !== 2'b01) begin n_fail++; $display("FAIL raw_rvalid: got %b want 01", {rvalid0, rvalid1}); end
        n_tests++; if (rdata !== 8'hC3) begin n_fail++; $display("FAIL raw_rdata: got %h want c3", rdata); end
        tick();
    endtask

    task automatic test_bypass();
        req0 = 1'b1; we0 = 1'b1; addr0 = 4'd7; wdata0 = 8'h3C;
        #1;
        n_tests++; if (gnt0 !== 1'b1) begin n_fail++; $display("FAIL bypass_wr_gnt: got %b want 1", gnt0); end
        tick();
        req0 = 1'b0; we0 = 1'b0; req1 = 1'b1; we1 = 1'b0; addr1 = 4'd8;
        #1;
        n_tests++; if (gnt1 !== 1'b1) begin n_fail++; $display("FAIL bypass_gnt1: got %b want 1", gnt1); end
        tick();
        req1 = 1'b0;
        #1;
        n_tests++; if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 4'd8}) begin n_fail++; $display("FAIL bypass_cmd: got %b%b%h want 108", mem_en, mem_we, mem_addr); end
        tick();
        #1;
        n_tests++; if ({rvalid0, rvalid1} !== 2'b01) begin n_fail++; $display("FAIL bypass_rvalid: got %b want 01", {rvalid0, rvalid1}); end
        n_tests++; if (rdata !== 8'h00) begin n_fail++; $display("FAIL bypass_rdata: got %h want 00", rdata); end
        repeat (3) tick();
    endtask

    task automatic test_halt();
        req0 = 1'b1; we0 = 1'b0; addr0 = 4'd3; req1 = 1'b1; we1 = 1'b0; addr1 = 4'd7;
        #1;
        n_tests++; if ({gnt0, gnt1} !== 2'b10) begin n_fail++; $display("FAIL halt_first_gnt: got %b want 10", {gnt0, gnt1}); end
        tick();
        req0 = 1'b0;
        #1;
        n_tests++; if (gnt1 !== 1'b1) begin n_fail++; $display("FAIL halt_second_gnt: got %b want 1", gnt1); end
        tick();
        req1 = 1'b0; req0 = 1'b1; halt = 1'b1;
        #1;
        n_tests++; if (gnt0 !== 1'b0) begin n_fail++; $display("FAIL halt_no_gnt_first: got %b want 0", gnt0); end
        n_tests++; if ({rvalid0, rdata} !== {1'b1, 8'h5A}) begin n_fail++; $display("FAIL halt_rvalid0: got %b/%h want 1/5a", rvalid0, rdata); end
        tick();
        #1;
        n_tests++; if ({gnt0, halted} !== 2'b00) begin n_fail++; $display("FAIL halt_drain1: got %b want 00", {gnt0, halted}); end
        n_tests++; if ({rvalid1, rdata} !== {1'b1, 8'h3C}) begin n_fail++; $display("FAIL halt_rvalid1: got %b/%h want 1/3c", rvalid1, rdata); end
        tick();
        #1;
        n_tests++; if ({gnt0, halted, mem_en} !== 3'b000) begin n_fail++; $display("FAIL halt_drain2: got %b want 000", {gnt0, halted, mem_en}); end
        tick();
        #1;
        n_tests++; if ({gnt0, halted} !== 2'b01) begin n_fail++; $display("FAIL halt_halted: got %b want 01", {gnt0, halted}); end
        halt = 1'b0;
        #1;
        n_tests++; if (gnt0 !== 1'b0) begin n_fail++; $display("FAIL halt_still_halted_gnt: got %b want 0", gnt0); end
        tick();
        #1;
        n_tests++; if ({gnt0, halted} !== 2'b10) begin n_fail++; $display("FAIL halt_resume: got %b want 10", {gnt0, halted}); end
        tick();
        req0 = 1'b0;
        tick();
        #1;
        n_tests++; if ({rvalid0, rdata} !== {1'b1, 8'h5A}) begin n_fail++; $display("FAIL halt_resume_rdata: got %b/%h want 1/5a", rvalid0, rdata); end
        tick();
    endtask

    task automatic test_drain_deassert();
        req0 = 1'b1; we0 = 1'b0; addr0 = 4'd3;
        #1;
        n_tests++; if (gnt0 !== 1'b1) begin n_fail++; $display("FAIL drain_gnt: got %b want 1", gnt0); end
        tick();
        req0 = 1'b0; halt = 1'b1;
        tick();
        halt = 1'b0; req0 = 1'b1;
        #1;
        n_tests++; if ({gnt0, halted, rvalid0} !== 3'b001) begin n_fail++; $display("FAIL drain_in_drain: got %b want 001", {gnt0, halted, rvalid0}); end
        tick();
        #1;
        n_tests++; if ({gnt0, halted} !== 2'b00) begin n_fail++; $display("FAIL drain_empty: got %b want 00", {gnt0, halted}); end
        tick();
        #1;
        n_tests++; if ({gnt0, halted} !== 2'b01) begin n_fail++; $display("FAIL drain_halted: got %b want 01", {gnt0, halted}); end
        tick();
        #1;
        n_tests++; if ({gnt0, halted} !== 2'b10) begin n_fail++; $display("FAIL drain_reactivate: got %b want 10", {gnt0, halted}); end
        tick();
        req0 = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_reset_mid_read();
        req0 = 1'b1; we0 = 1'b0; addr0 = 4'd3;
        #1;
        n_tests++; if (gnt0 !== 1'b1) begin n_fail++; $display("FAIL rstmid_gnt: got %b want 1", gnt0); end
        tick();
        req0 = 1'b0; rst_n = 1'b0;
        #1;
        n_tests++; if ({mem_en, rvalid0} !== 2'b00) begin n_fail++; $display("FAIL rstmid_async_clear: got %b want 00", {mem_en, rvalid0}); end
        tick();
        rst_n = 1'b1;
        #1;
        n_tests++; if ({rvalid0, rvalid1, mem_en} !== 3'b000) begin n_fail++; $display("FAIL rstmid_no_rvalid: got %b want 000", {rvalid0, rvalid1, mem_en}); end
        n_tests++; if (rdata !== 8'h00) begin n_fail++; $display("FAIL rstmid_rdata: got %h want 00", rdata); end
        tick();
        req1 = 1'b1; we1 = 1'b0; addr1 = 4'd5;
        #1;
        n_tests++; if ({gnt1, halted} !== 2'b10) begin n_fail++; $display("FAIL rstmid_active: got %b want 10", {gnt1, halted}); end
        tick();
        req1 = 1'b0;
        #1;
        n_tests++; if ({mem_en, mem_addr} !== {1'b1, 4'd5}) begin n_fail++; $display("FAIL rstmid_cmd: got %b%h want 15", mem_en, mem_addr); end
        tick();
    endtask

    initial begin
        rst_n = 1'b0; halt = 1'b0;
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = 4'h0; addr1 = 4'h0; wdata0 = 8'h00; wdata1 = 8'h00;
        test_reset();
        test_contention();
        test_write();
        test_single_read();
        test_raw_hazard();
        test_bypass();
        test_halt();
        test_drain_deassert();
        test_reset_mid_read();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dpram_port_arbiter.md
Name: dpram_port_arbiter

Overview:
- Shares one port of the latency-wrapped dual-port RAM between two requesters (req0, req1), with round-robin arbitration.
- Registers the winning command onto the RAM port interface: enable, write-enable, address and data.
- Tracks in-flight writes and stalls any read that would hit an address still inside the write-latency window.
- Routes read data back to the issuing requester; provides a halt/drain sequence for safe reconfiguration or power-down.

Parameters:
- DATA_WIDTH, 8, requester data width; RAM data bus is DATA_WIDTH bits.
- ADDR_WIDTH, 4, RAM address width.
- WR_LATENCY, 1, RAM write latency in cycles from registered command to memory update; range 1..8.
- RD_LATENCY, 1, RAM read latency in cycles from registered command to valid i_mem_dout; range 1..8.

Ports:
- clk  input  1  single clock for all logic.
- rst_n  input  1  asynchronous active-low reset.
- i_req0, i_req1  input  1  request; held until granted.
- i_we0, i_we1  input  1  1=write, 0=read; stable while request held.
- i_addr0, i_addr1  input  ADDR_WIDTH  request address.
- i_wdata0, i_wdata1  input  DATA_WIDTH  write data.
- o_gnt0, o_gnt1  output  1  combinational grant, same cycle the request is accepted.
- o_rvalid0, o_rvalid1  output  1  one-cycle read-data-valid pulse.
- o_rdata  output  DATA_WIDTH  read data, valid when either rvalid is 1.
- i_halt  input  1  stop accepting requests and drain.
- o_halted  output  1  drained, no traffic in flight.
- o_mem_en, o_mem_we  output  1  registered RAM enable / write enable.
- o_mem_addr  output  ADDR_WIDTH  registered RAM address.
- o_mem_din  output  DATA_WIDTH  registered RAM write data.
- i_mem_dout  input  DATA_WIDTH  RAM read data.

Behaviour:
- Reset values (rst_n low, async): all o_mem_* = 0, o_rvalid* = 0, o_rdata = 0, o_halted = 0, state = ACTIVE, RR pointer = 0 (req0 preferred), both scoreboards cleared.
- Eligibility: a requester is eligible when its req=1, state=ACTIVE, and it is not hazard-blocked.
- Hazard block: a read is blocked when its address matches any valid entry in the write scoreboard.
  - Write scoreboard: shift register of WR_LATENCY+1 entries, each {valid, addr}; loaded on every granted write, shifted every cycle.
- Arbitration:
  - At most one grant per cycle.
  - If both requesters are eligible, the RR pointer's requester wins; the pointer then moves to the other requester.
  - If only one is eligible, it wins; the pointer moves to the loser's index.
  - If neither is eligible, the pointer holds.
  - A blocked read never prevents the other requester from being granted.
- Issue: a grant in cycle T drives o_mem_en=1, o_mem_we=we, addr and din at edge T+1. o_mem_en=0 in any cycle with no grant.
- Read return:
  - Tag pipeline of RD_LATENCY+1 stages, each {valid, id}.
  - o_rvalidN pulses in cycle T+1+RD_LATENCY.
  - o_rdata is registered from i_mem_dout in that same cycle.
  - Back-to-back reads return in grant order, one per cycle.
- Writes never produce rvalid.
- State machine:
  - ACTIVE: normal operation. i_halt=1 moves to DRAIN at the next edge; no grants in the cycle i_halt is first seen.
  - DRAIN: no grants. When both scoreboards are empty, move to HALTED.
  - HALTED: o_halted=1. i_halt=0 moves to ACTIVE at the next edge, and o_halted drops with the state change.
  - i_halt deasserted during DRAIN: DRAIN still completes to HALTED, then returns to ACTIVE on the following edge.
- Wrap-around: the address is used as-is; there is no range check.
- Reset mid-operation: all in-flight tags and scoreboard entries are discarded; no rvalid is produced for reads granted before reset.

Optional Feature:
- Macro: ARB_FIXED_PRIO_EN.
- Defined: fixed priority, req0 always wins over req1; the RR pointer is removed. req1 can starve under continuous req0.
- Undefined: round-robin exactly as specified above.

Test Plan:
- Single read: req0 read addr 3, memory holding 0x5A, RD_LATENCY=1 -> o_gnt0 in cycle T; o_mem_en=1, we=0, addr=3 at T+1; o_rvalid0=1, o_rdata=0x5A at T+2.
- Contention: req0 and req1 both read, continuously for 6 cycles -> grants alternate 0,1,0,1,0,1; rvalid ids follow the same order.
- RAW hazard, WR_LATENCY=2: req0 writes 0xC3 to addr 7, req1 reads addr 7 in the next cycle -> req1 stalled for 3 cycles; rdata=0xC3.
- Non-hazard bypass: the same write is pending while req1 reads addr 8 -> req1 is granted the cycle after the write grant with no stall.
- Halt: i_halt asserted with 2 reads in flight -> no further grants; both rvalids still delivered; o_halted=1 once the pipelines empty; deassert i_halt -> grants resume next cycle.
- Reset mid-read: rst_n pulsed low 1 cycle after a read grant -> o_rvalid* stays 0; o_mem_en=0; state=ACTIVE.
